muldiv_iter_unit: RTL and testbench

//  Iterative RV M-extension execute unit: MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU.

---
 rtl/muldiv_iter_unit.sv | 192 +++++++++++++++++++
 tb/tb_muldiv_iter_unit.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_iter_unit.sv
// Iterative RV M-extension execute unit (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU).
// Sits beside the single-cycle ALU and stalls the pipeline through a valid/ready handshake.
// Multiply and divide both work on operand magnitudes; the sign is applied in one final cycle.
//
// state | meaning
// IDLE  | ready to accept a new op (in_ready_o high)
// CALC  | retiring MUL_STEP multiplier bits or DIV_STEP quotient bits per cycle
// FIX   | apply sign correction and select the result half / quotient / remainder
// DONE  | result presented on result_o, held until out_ready_i
module muldiv_iter_unit #(
    parameter int XLEN     = 32,
    parameter int MUL_STEP = 4,
    parameter int DIV_STEP = 1
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] op_a_i,
    input  logic [XLEN-1:0] op_b_i,
    input  logic            flush_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [XLEN-1:0] result_o,
    output logic            busy_o
);

    localparam int               CNT_W    = $clog2(XLEN + 1);
    localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(XLEN / MUL_STEP - 1);
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(XLEN / DIV_STEP - 1);
    localparam logic [XLEN-1:0]  INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [2:0]         f3_q, f3_d;
    logic [XLEN-1:0]    opb_q, opb_d;      // multiplicand or divisor magnitude
    logic [2*XLEN-1:0]  acc_q, acc_d;      // mul: {partial high, multiplier}; div: {remainder, quotient}
    logic               neg_q, neg_d;      // negate product / quotient at the end
    logic               rneg_q, rneg_d;    // negate remainder at the end
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0]    res_q, res_d;

    logic               in_div, a_sgn, b_sgn, a_neg, b_neg;
    logic [XLEN-1:0]    a_mag, b_mag;
    logic               fast;
    logic [XLEN-1:0]    fast_res;

    logic [XLEN+MUL_STEP-1:0] mul_sum;
    logic [2*XLEN-1:0]  mul_next, div_next, prod_fix;
    logic [XLEN:0]      div_trial;
    logic [XLEN-1:0]    quo_fix, rem_fix, fix_res;

    // Decode the incoming op: signedness, magnitudes and the no-iteration special cases.
    always_comb begin
        in_div   = funct3_i[2];
        a_sgn    = in_div ? ~funct3_i[0] : (funct3_i[1:0] == 2'b01 || funct3_i[1:0] == 2'b10);
        b_sgn    = in_div ? ~funct3_i[0] : (funct3_i[1:0] == 2'b01);
        a_neg    = a_sgn & op_a_i[XLEN-1];
        b_neg    = b_sgn & op_b_i[XLEN-1];
        a_mag    = a_neg ? -op_a_i : op_a_i;
        b_mag    = b_neg ? -op_b_i : op_b_i;
        fast     = 1'b0;
        fast_res = '0;
        if (in_div) begin
            if (op_b_i == '0) begin
                fast     = 1'b1;
                fast_res = funct3_i[1] ? op_a_i : '1;
            end else if (!funct3_i[0] && op_a_i == INT_MIN && op_b_i == '1) begin
                fast     = 1'b1;
                fast_res = funct3_i[1] ? '0 : op_a_i;
            end
        end else if (op_a_i == '0 || op_b_i == '0) begin
            fast     = 1'b1;
            fast_res = '0;
        end
    end

    // One iteration of shift-add multiply / restoring divide, plus the final sign fix.
    always_comb begin
        mul_sum  = {{MUL_STEP{1'b0}}, acc_q[2*XLEN-1:XLEN]}
                 + {{MUL_STEP{1'b0}}, opb_q} * {{XLEN{1'b0}}, acc_q[MUL_STEP-1:0]};
        mul_next = {mul_sum, acc_q[XLEN-1:MUL_STEP]};

        div_next  = acc_q;
        div_trial = '0;
        for (int i = 0; i < DIV_STEP; i++) begin
            // Remainder shifted left with the next dividend bit, minus the divisor.
            div_trial = div_next[2*XLEN-1:XLEN-1] - {1'b0, opb_q};
            if (!div_trial[XLEN]) begin
                div_next = {div_trial[XLEN-1:0], div_next[XLEN-2:0], 1'b1};
            end else begin
                div_next = {div_next[2*XLEN-2:0], 1'b0};
            end
        end

        prod_fix = neg_q  ? -acc_q : acc_q;
        quo_fix  = neg_q  ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
        rem_fix  = rneg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
        if (f3_q[2]) begin
            fix_res = f3_q[1] ? rem_fix : quo_fix;
        end else begin
            fix_res = (f3_q[1:0] == 2'b00) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
        end
    end

    // Next-state and datapath-load logic; flush overrides everything.
    always_comb begin
        state_d = state_q;
        f3_d    = f3_q;
        opb_d   = opb_q;
        acc_d   = acc_q;
        neg_d   = neg_q;
        rneg_d  = rneg_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid_i) begin
                    f3_d = funct3_i;
                    if (fast) begin
                        res_d   = fast_res;
                        state_d = S_DONE;
                    end else begin
                        acc_d   = in_div ? {{XLEN{1'b0}}, a_mag} : {{XLEN{1'b0}}, b_mag};
                        opb_d   = in_div ? b_mag : a_mag;
                        neg_d   = a_neg ^ b_neg;
                        rneg_d  = a_neg;
                        cnt_d   = '0;
                        state_d = S_CALC;
                    end
                end
            end
            S_CALC: begin
                acc_d = f3_q[2] ? div_next : mul_next;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == (f3_q[2] ? DIV_LAST : MUL_LAST)) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                res_d   = fix_res;
                state_d = S_DONE;
            end
            S_DONE: begin
                if (out_ready_i) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (flush_i) begin
            state_d = S_IDLE;
            res_d   = res_q;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            f3_q    <= '0;
            opb_q   <= '0;
            acc_q   <= '0;
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
            cnt_q   <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            f3_q    <= f3_d;
            opb_q   <= opb_d;
            acc_q   <= acc_d;
            neg_q   <= neg_d;
            rneg_q  <= rneg_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
        end
    end

    assign in_ready_o  = (state_q == S_IDLE);
    assign busy_o      = (state_q != S_IDLE);
    assign out_valid_o = (state_q == S_DONE);
    assign result_o    = res_q;

endmodule

// File: tb/tb_muldiv_iter_unit.sv
// Scoreboard bench for muldiv_iter_unit: the driver pushes reference results and expected
// arrival cycles, a monitor pops and compares whenever the unit presents a result.
module tb_muldiv_iter_unit;

    localparam int XLEN    = 32;
    localparam int MUL_LAT = XLEN / 4 + 2;
    localparam int DIV_LAT = XLEN / 1 + 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  funct3;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        flush;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] result;
    logic        busy;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int ready_mode = 0;   // 0 random, 1 hold low, 2 always ready

    logic [31:0] exp_res_q[$];
    int          exp_cyc_q[$];

    muldiv_iter_unit #(.XLEN(32), .MUL_STEP(4), .DIV_STEP(1)) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .in_valid_i (in_valid),
        .in_ready_o (in_ready),
        .funct3_i   (funct3),
        .op_a_i     (op_a),
        .op_b_i     (op_b),
        .flush_i    (flush),
        .out_valid_o(out_valid),
        .out_ready_i(out_ready),
        .result_o   (result),
        .busy_o     (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: RISC-V M semantics computed with 64-bit arithmetic.
    function automatic logic [31:0] ref_res(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, ua, ub;
        logic [63:0] p;
        logic [31:0] r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'b0, a});
        ub = longint'({32'b0, b});
        p  = '0;
        r  = '0;
        case (f)
            3'b000: begin p = ua * ub; r = p[31:0];  end
            3'b001: begin p = sa * sb; r = p[63:32]; end
            3'b010: begin p = sa * ub; r = p[63:32]; end
            3'b011: begin p = ua * ub; r = p[63:32]; end
            3'b100: begin
                if (b == 0) r = 32'hFFFF_FFFF;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = a;
                else r = $signed(a) / $signed(b);
            end
            3'b101: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'b110: begin
                if (b == 0) r = a;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h0;
                else r = $signed(a) % $signed(b);
            end
            default: r = (b == 0) ? a : a % b;
        endcase
        return r;
    endfunction

    function automatic bit ref_fast(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        if (f[2]) return (b == 0) || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
        return (a == 0) || (b == 0);
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            5: return 32'($urandom_range(0, 20));
            default: return $urandom();
        endcase
    endfunction

    // Called at a negedge; waits for in_ready, presents one op for one cycle.
    task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        int n = 0;
        int lat;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            total++;
            bad++;
            $display("FAIL issue_timeout: in_ready low for %0d cycles, required 1", n);
            return;
        end
        lat = ref_fast(f, a, b) ? 1 : (f[2] ? DIV_LAT : MUL_LAT);
        exp_res_q.push_back(ref_res(f, a, b));
        exp_cyc_q.push_back(cyc + lat);
        in_valid = 1'b1;
        funct3   = f;
        op_a     = a;
        op_b     = b;
        @(negedge clk);
        in_valid = 1'b0;
        funct3   = 3'($urandom());
        op_a     = $urandom();
        op_b     = $urandom();
        chk("in_ready_after_accept", {31'b0, in_ready}, 32'h0);
        chk("busy_after_accept", {31'b0, busy}, 32'h1);
    endtask

    task automatic drain();
        int n = 0;
        while (exp_res_q.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (exp_res_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: %0d results outstanding, required 0", exp_res_q.size());
            exp_res_q.delete();
            exp_cyc_q.delete();
        end
    endtask

    // Monitor: compares every presented result against the scoreboard head.
    logic        seen = 1'b0;
    logic [31:0] held = '0;
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                seen      = 1'b0;
                out_ready = 1'b0;
            end else if (out_valid) begin
                if (exp_res_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_valid: got result 0x%08h, required no out_valid (cycle %0d)", result, cyc);
                    out_ready = 1'b1;
                end else begin
                    if (!seen) begin
                        chk("result", result, exp_res_q[0]);
                        chk("latency", 32'(cyc), 32'(exp_cyc_q[0]));
                        held = result;
                        seen = 1'b1;
                    end else begin
                        chk("hold_stable", result, held);
                    end
                    case (ready_mode)
                        1:       out_ready = 1'b0;
                        2:       out_ready = 1'b1;
                        default: out_ready = ($urandom_range(0, 2) != 0);
                    endcase
                    if (out_ready) begin
                        void'(exp_res_q.pop_front());
                        void'(exp_cyc_q.pop_front());
                        seen = 1'b0;
                    end
                end
            end else begin
                out_ready = ($urandom_range(0, 1) == 1);
            end
        end
    end

    initial begin
        int n;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        funct3   = '0;
        op_a     = '0;
        op_b     = '0;
        flush    = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_in_ready", {31'b0, in_ready}, 32'h1);
        chk("reset_out_valid", {31'b0, out_valid}, 32'h0);
        chk("reset_busy", {31'b0, busy}, 32'h0);
        chk("reset_result", result, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        issue(3'b000, 32'd7, 32'hFFFF_FFFD);
        issue(3'b001, 32'h8000_0000, 32'h8000_0000);
        issue(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        issue(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        issue(3'b100, 32'hFFFF_FFF9, 32'd2);
        issue(3'b110, 32'hFFFF_FFF9, 32'd2);
        issue(3'b101, 32'd100, 32'd7);
        issue(3'b111, 32'd100, 32'd7);
        issue(3'b101, 32'd5, 32'd0);
        issue(3'b111, 32'd5, 32'd0);
        issue(3'b100, 32'h8000_0000, 32'hFFFF_FFFF);
        issue(3'b110, 32'h8000_0000, 32'hFFFF_FFFF);
        issue(3'b000, 32'd0, 32'h1234_5678);
        drain();

        // Consumer stalls for 5 cycles in DONE, then takes the result.
        ready_mode = 1;
        issue(3'b101, 32'd100, 32'd7);
        n = 0;
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        repeat (5) @(negedge clk);
        chk("hold_out_valid", {31'b0, out_valid}, 32'h1);
        chk("hold_result", result, 32'd14);
        @(posedge clk);
        #1 ready_mode = 2;
        @(negedge clk);
        @(negedge clk);
        chk("release_in_ready", {31'b0, in_ready}, 32'h1);
        chk("release_out_valid", {31'b0, out_valid}, 32'h0);
        ready_mode = 0;
        drain();

        // Flush at CALC iteration 10 of a divide.
        in_valid = 1'b1;
        funct3   = 3'b100;
        op_a     = 32'd1000;
        op_b     = 32'd3;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (10) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_in_ready", {31'b0, in_ready}, 32'h1);
        chk("flush_busy", {31'b0, busy}, 32'h0);
        chk("flush_out_valid", {31'b0, out_valid}, 32'h0);
        repeat (40) @(negedge clk);

        // Flush beats accept in the same cycle.
        in_valid = 1'b1;
        funct3   = 3'b000;
        op_a     = 32'd3;
        op_b     = 32'd5;
        flush    = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        flush    = 1'b0;
        chk("flush_vs_accept_in_ready", {31'b0, in_ready}, 32'h1);
        chk("flush_vs_accept_busy", {31'b0, busy}, 32'h0);
        repeat (15) @(negedge clk);

        // Asynchronous reset in the middle of a multiply.
        in_valid = 1'b1;
        funct3   = 3'b000;
        op_a     = 32'd123;
        op_b     = 32'd456;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("async_rst_in_ready", {31'b0, in_ready}, 32'h1);
        chk("async_rst_busy", {31'b0, busy}, 32'h0);
        chk("async_rst_out_valid", {31'b0, out_valid}, 32'h0);
        chk("async_rst_result", result, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);

        for (int k = 0; k < 300; k++) begin
            issue(3'($urandom()), pick(), pick());
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
